// File: rtl/axi_i2c_pkg.sv
// Shared definitions for the AXI4-Lite to I2C bridge front end: bus widths,
// response encodings and the write/read FSM state types.
package axi_i2c_pkg;

  localparam int AXI_ADDR_W     = 32;
  localparam int AXI_DATA_W     = 32;
  localparam int AXI_RESP_W     = 2;
  localparam int I2C_RDATA_W    = 8;
  localparam int I2C_OUT_W      = 16;
  localparam int I2C_TIMEOUT    = 1024;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_WAIT,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_TRIG,
    R_WAIT,
    R_RESP
  } rd_state_t;

endpackage

// File: rtl/axi_i2c_rd_path.sv
// Read path of the AXI4-Lite to I2C bridge: accepts one AR beat, triggers the
// I2C master, captures the returned byte and presents it on the R channel.
// Optional macro I2C_TIMEOUT_EN adds a response timeout in R_WAIT.
module axi_i2c_rd_path
  import axi_i2c_pkg::*;
#(
  parameter int RDATA_WIDTH    = I2C_RDATA_W,
  parameter int RESP_WIDTH     = AXI_RESP_W,
  parameter int TIMEOUT_CYCLES = I2C_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [7:0]             araddr,
  input  logic                   wr_busy,
  input  logic                   pending,
  output logic                   trigger,
  output logic [7:0]             trig_addr,
  input  logic [RDATA_WIDTH-1:0] rdata_in,
  input  logic                   rdata_valid,
  output logic                   rdata_valid_ack,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [RDATA_WIDTH-1:0] rdata,
  output logic [RESP_WIDTH-1:0]  rresp
);

  rd_state_t state, state_next;
  logic      run;
  logic      rd_done;
  logic      rd_tmo;

`ifdef I2C_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // Count cycles spent waiting for the I2C byte; cleared in every other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tmo_cnt <= '0;
    else if (state == R_WAIT)  tmo_cnt <= tmo_cnt + 1'b1;
    else                       tmo_cnt <= '0;
  end

  assign rd_tmo = (state == R_WAIT) && !rdata_valid &&
                  (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign rd_tmo = 1'b0;
`endif

  assign rd_done   = (state == R_WAIT) && (rdata_valid || rd_tmo);
  assign arready   = run && (state == R_IDLE);
  assign trigger   = (state == R_TRIG) && !pending && !wr_busy;
  assign rvalid    = (state == R_RESP);

  // State register plus captured address, read byte and response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= R_IDLE;
      run             <= 1'b0;
      trig_addr       <= '0;
      rdata           <= '0;
      rresp           <= '0;
      rdata_valid_ack <= 1'b0;
    end else begin
      state           <= state_next;
      run             <= 1'b1;
      rdata_valid_ack <= 1'b0;
      if (arvalid && arready) trig_addr <= araddr;
      if (rd_done) begin
        if (rdata_valid) begin
          rdata           <= rdata_in;
          rresp           <= RESP_WIDTH'(RESP_OKAY);
          rdata_valid_ack <= 1'b1;
        end else begin
          rdata <= '0;
          rresp <= RESP_WIDTH'(RESP_SLVERR);
        end
      end
    end
  end

  // Next-state decode for the read sequence.
  always_comb begin
    state_next = state;
    unique case (state)
      R_IDLE: if (arvalid && arready) state_next = R_TRIG;
      R_TRIG: if (trigger)            state_next = R_WAIT;
      R_WAIT: if (rd_done)            state_next = R_RESP;
      R_RESP: if (rready)             state_next = R_IDLE;
      default:                        state_next = R_IDLE;
    endcase
  end

endmodule

// File: rtl/axi_slave_i2c.sv
// AXI4-Lite slave front end of the AXI-to-I2C bridge. Holds the write FSM and
// the shared ADDR_DATA_OUT driver; the read FSM lives in axi_i2c_rd_path.
// Optional macro I2C_TIMEOUT_EN adds a response timeout to both paths.
module axi_slave_i2c
  import axi_i2c_pkg::*;
#(
  parameter int ADDR_WIDTH     = AXI_ADDR_W,
  parameter int DATA_WIDTH     = AXI_DATA_W,
  parameter int RESP_WIDTH     = AXI_RESP_W,
  parameter int RDATA_WIDTH    = I2C_RDATA_W,
  parameter int OUT_WIDTH      = I2C_OUT_W,
  parameter int TIMEOUT_CYCLES = I2C_TIMEOUT
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  output logic                   AWREADY,
  input  logic                   AWVALID,
  input  logic [ADDR_WIDTH-1:0]  AWADDR,
  output logic                   WREADY,
  input  logic                   WVALID,
  input  logic [DATA_WIDTH-1:0]  WDATA,
  output logic [RESP_WIDTH-1:0]  BRESP,
  output logic                   BVALID,
  input  logic                   BREADY,
  output logic                   ARREADY,
  input  logic                   ARVALID,
  input  logic [ADDR_WIDTH-1:0]  ARADDR,
  output logic [RESP_WIDTH-1:0]  RRESP,
  output logic [RDATA_WIDTH-1:0] RDATA,
  output logic                   RVALID,
  input  logic                   RREADY,
  output logic [OUT_WIDTH-1:0]   ADDR_DATA_OUT,
  output logic                   VALID_ADDR_DATA_OUT,
  input  logic                   VALID_ADDR_DATA_OUT_ACK,
  input  logic                   VALID_ADDR_DATA_OUT_ACK_VALID,
  output logic                   I2C_MASTER_TRIGGER,
  input  logic [RDATA_WIDTH-1:0] RDATA_OUT,
  input  logic                   RDATA_VALID,
  output logic                   RDATA_VALID_ACK,
  input  logic                   PENDING_TRANSACTION_WR,
  input  logic                   PENDING_TRANSACTION_RD
);

  wr_state_t w_state, w_next;
  // Held low through reset and the first cycle after it, so no READY is
  // offered while the block is still coming out of reset.
  logic      run;
  logic      aw_full, w_full;
  logic [7:0] aw_byte, w_byte;
  logic [RESP_WIDTH-1:0] bresp_q;
  logic [OUT_WIDTH-1:0]  ado_q;
  logic      aw_hs, w_hs;
  logic      w_done, w_tmo;
  logic      rd_trig;
  logic [7:0] rd_addr_byte;

  // Only the low address/data bytes reach the I2C side.
  logic unused_bits;
  assign unused_bits = ^{AWADDR[ADDR_WIDTH-1:8], ARADDR[ADDR_WIDTH-1:8],
                         WDATA[DATA_WIDTH-1:8]};

  assign AWREADY             = run && (w_state == W_IDLE) && !aw_full;
  assign WREADY              = run && (w_state == W_IDLE) && !w_full;
  assign aw_hs               = AWVALID && AWREADY;
  assign w_hs                = WVALID && WREADY;
  assign VALID_ADDR_DATA_OUT = (w_state == W_REQ);
  assign BVALID              = (w_state == W_RESP);
  assign BRESP               = bresp_q;

`ifdef I2C_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] w_tmo_cnt;

  // Count cycles spent waiting for the I2C write ACK; cleared elsewhere.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)                w_tmo_cnt <= '0;
    else if (w_state == W_WAIT)  w_tmo_cnt <= w_tmo_cnt + 1'b1;
    else                         w_tmo_cnt <= '0;
  end

  assign w_tmo = (w_state == W_WAIT) && !VALID_ADDR_DATA_OUT_ACK_VALID &&
                 (w_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo = 1'b0;
`endif

  assign w_done = (w_state == W_WAIT) && (VALID_ADDR_DATA_OUT_ACK_VALID || w_tmo);

  // Write state register, AW/W holding buffers and latched BRESP.
  // NOTE: async active-low reset; every register in this file assigns with <=
  // so all flops sample the same pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state <= W_IDLE;
      run     <= 1'b0;
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_byte <= '0;
      w_byte  <= '0;
      bresp_q <= '0;
      ado_q   <= '0;
    end else begin
      w_state <= w_next;
      run     <= 1'b1;
      ado_q   <= ADDR_DATA_OUT;
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_byte <= AWADDR[7:0];
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_byte <= WDATA[7:0];
      end
      if (BVALID && BREADY) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end
      if (w_done) begin
        bresp_q <= (VALID_ADDR_DATA_OUT_ACK_VALID && VALID_ADDR_DATA_OUT_ACK)
                   ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
      end
    end
  end

  // Next-state decode for the write sequence.
  // NOTE: next-state gets its default before the case so no path infers a latch.
  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE: if (aw_full && w_full && !PENDING_TRANSACTION_WR) w_next = W_REQ;
      W_REQ:                                                    w_next = W_WAIT;
      W_WAIT: if (w_done)                                       w_next = W_RESP;
      W_RESP: if (BREADY)                                       w_next = W_IDLE;
      default:                                                  w_next = W_IDLE;
    endcase
  end

  // Shared I2C address/data bus: write request wins, then read trigger,
  // otherwise hold the last value driven.
  always_comb begin
    ADDR_DATA_OUT = ado_q;
    if (w_state == W_REQ)  ADDR_DATA_OUT = OUT_WIDTH'({aw_byte, w_byte});
    else if (rd_trig)      ADDR_DATA_OUT = OUT_WIDTH'({rd_addr_byte, 8'h00});
  end

  assign I2C_MASTER_TRIGGER = rd_trig;

  axi_i2c_rd_path #(
    .RDATA_WIDTH    (RDATA_WIDTH),
    .RESP_WIDTH     (RESP_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rd_path (
    .clk             (ACLK),
    .rst_n           (ARESETn),
    .arvalid         (ARVALID),
    .arready         (ARREADY),
    .araddr          (ARADDR[7:0]),
    .wr_busy         (w_state == W_REQ),
    .pending         (PENDING_TRANSACTION_RD),
    .trigger         (rd_trig),
    .trig_addr       (rd_addr_byte),
    .rdata_in        (RDATA_OUT),
    .rdata_valid     (RDATA_VALID),
    .rdata_valid_ack (RDATA_VALID_ACK),
    .rvalid          (RVALID),
    .rready          (RREADY),
    .rdata           (RDATA),
    .rresp           (RRESP)
  );

endmodule

// File: tb/tb_axi_slave_i2c.sv
// Scoreboard testbench for axi_slave_i2c: stimulus pushes expected I2C
// requests and AXI responses into queues, a negedge monitor pops and compares.
module tb_axi_slave_i2c;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        AWREADY, AWVALID = 1'b0;
  logic [31:0] AWADDR = '0;
  logic        WREADY, WVALID = 1'b0;
  logic [31:0] WDATA = '0;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY = 1'b0;
  logic        ARREADY, ARVALID = 1'b0;
  logic [31:0] ARADDR = '0;
  logic [1:0]  RRESP;
  logic [7:0]  RDATA;
  logic        RVALID, RREADY = 1'b0;
  logic [15:0] ADDR_DATA_OUT;
  logic        VALID_ADDR_DATA_OUT;
  logic        ACK = 1'b0, ACK_VALID = 1'b0;
  logic        I2C_MASTER_TRIGGER;
  logic [7:0]  RDATA_OUT = '0;
  logic        RDATA_VALID = 1'b0;
  logic        RDATA_VALID_ACK;
  logic        PENDING_WR = 1'b0, PENDING_RD = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_req[$];
  logic [15:0] exp_trig[$];
  logic [1:0]  exp_b[$];
  logic [9:0]  exp_r[$];
  logic        exp_rack[$];

  always #5 ACLK = ~ACLK;

  axi_slave_i2c dut (
    .ACLK                          (ACLK),
    .ARESETn                       (ARESETn),
    .AWREADY                       (AWREADY),
    .AWVALID                       (AWVALID),
    .AWADDR                        (AWADDR),
    .WREADY                        (WREADY),
    .WVALID                        (WVALID),
    .WDATA                         (WDATA),
    .BRESP                         (BRESP),
    .BVALID                        (BVALID),
    .BREADY                        (BREADY),
    .ARREADY                       (ARREADY),
    .ARVALID                       (ARVALID),
    .ARADDR                        (ARADDR),
    .RRESP                         (RRESP),
    .RDATA                         (RDATA),
    .RVALID                        (RVALID),
    .RREADY                        (RREADY),
    .ADDR_DATA_OUT                 (ADDR_DATA_OUT),
    .VALID_ADDR_DATA_OUT           (VALID_ADDR_DATA_OUT),
    .VALID_ADDR_DATA_OUT_ACK       (ACK),
    .VALID_ADDR_DATA_OUT_ACK_VALID (ACK_VALID),
    .I2C_MASTER_TRIGGER            (I2C_MASTER_TRIGGER),
    .RDATA_OUT                     (RDATA_OUT),
    .RDATA_VALID                   (RDATA_VALID),
    .RDATA_VALID_ACK               (RDATA_VALID_ACK),
    .PENDING_TRANSACTION_WR        (PENDING_WR),
    .PENDING_TRANSACTION_RD        (PENDING_RD)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic sel_sig(input int sel);
    case (sel)
      0:       return VALID_ADDR_DATA_OUT;
      1:       return BVALID;
      2:       return I2C_MASTER_TRIGGER;
      3:       return RVALID;
      4:       return AWREADY;
      5:       return WREADY;
      default: return ARREADY;
    endcase
  endfunction

  // Wait (bounded) at negedges until the selected DUT signal is high.
  task automatic wait_cond(input int sel, input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge ACLK);
      if (sel_sig(sel)) break;
    end
    check(name, 32'(sel_sig(sel)), 32'd1);
  endtask

  task automatic send_aw(input logic [31:0] a);
    @(posedge ACLK); #1;
    AWVALID = 1'b1; AWADDR = a;
    wait_cond(4, "awready_wait");
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    @(negedge ACLK);
    check("awready_drop", 32'(AWREADY), 32'd0);
  endtask

  task automatic send_w(input logic [31:0] d);
    @(posedge ACLK); #1;
    WVALID = 1'b1; WDATA = d;
    wait_cond(5, "wready_wait");
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    @(negedge ACLK);
    check("wready_drop", 32'(WREADY), 32'd0);
  endtask

  task automatic send_ar(input logic [31:0] a);
    @(posedge ACLK); #1;
    ARVALID = 1'b1; ARADDR = a;
    wait_cond(6, "arready_wait");
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    @(negedge ACLK);
    check("arready_drop", 32'(ARREADY), 32'd0);
  endtask

  task automatic ack_pulse(input logic ack_bit);
    @(posedge ACLK); #1;
    ACK_VALID = 1'b1; ACK = ack_bit;
    @(posedge ACLK); #1;
    ACK_VALID = 1'b0; ACK = 1'b0;
  endtask

  // Full write with BREADY already high: wait request, answer, collect B.
  task automatic finish_write(input logic ack_bit);
    wait_cond(0, "req_wait");
    ack_pulse(ack_bit);
    wait_cond(1, "bvalid_wait");
    @(posedge ACLK); #1;
  endtask

  // Scoreboard monitor: every DUT output event pops its expected value.
  always @(negedge ACLK) begin
    if (ARESETn) begin
      if (VALID_ADDR_DATA_OUT) begin
        if (exp_req.size() == 0) check("unexpected_req", 32'(VALID_ADDR_DATA_OUT), 32'd0);
        else check("req_addr_data", 32'(ADDR_DATA_OUT), 32'(exp_req.pop_front()));
      end
      if (I2C_MASTER_TRIGGER) begin
        if (exp_trig.size() == 0) check("unexpected_trig", 32'(I2C_MASTER_TRIGGER), 32'd0);
        else check("trig_addr_data", 32'(ADDR_DATA_OUT), 32'(exp_trig.pop_front()));
      end
      if (BVALID && BREADY) begin
        if (exp_b.size() == 0) check("unexpected_b", 32'(BVALID), 32'd0);
        else check("bresp", 32'(BRESP), 32'(exp_b.pop_front()));
      end
      if (RVALID && RREADY) begin
        if (exp_r.size() == 0) check("unexpected_r", 32'(RVALID), 32'd0);
        else check("rdata_rresp", 32'({RDATA, RRESP}), 32'(exp_r.pop_front()));
      end
      if (RDATA_VALID_ACK) begin
        if (exp_rack.size() == 0) check("unexpected_rack", 32'(RDATA_VALID_ACK), 32'd0);
        else check("rdata_valid_ack", 32'(RDATA_VALID_ACK), 32'(exp_rack.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (2) @(negedge ACLK);
    check("rst_flags", 32'({AWREADY, WREADY, BVALID, ARREADY, RVALID,
                            VALID_ADDR_DATA_OUT, I2C_MASTER_TRIGGER, RDATA_VALID_ACK,
                            BRESP, RRESP, RDATA}), 32'd0);
    check("rst_ado", 32'(ADDR_DATA_OUT), 32'd0);
    ARESETn = 1'b1;
    BREADY  = 1'b1;
    RREADY  = 1'b1;

    // Stray strobes while idle must be ignored (monitor flags any response).
    @(posedge ACLK); #1;
    ACK_VALID = 1'b1; RDATA_VALID = 1'b1; RDATA_OUT = 8'hFF;
    @(posedge ACLK); #1;
    ACK_VALID = 1'b0; RDATA_VALID = 1'b0;
    repeat (3) @(negedge ACLK);
    check("idle_no_resp", 32'({BVALID, RVALID, RDATA_VALID_ACK}), 32'd0);
    RREADY = 1'b0;

    // Address first, data two cycles later, ACK -> OKAY.
    exp_req.push_back(16'h0101); exp_b.push_back(2'b00);
    send_aw(32'h1234_0001);
    repeat (2) @(posedge ACLK);
    send_w(32'h0000_0001);
    finish_write(1'b1);

    // Data before address.
    exp_req.push_back(16'h1D02); exp_b.push_back(2'b00);
    send_w(32'h0000_0002);
    send_aw(32'h1234_AA1D);
    finish_write(1'b1);

    // Both in the same cycle, NACK -> SLVERR, BREADY low for 5 cycles.
    BREADY = 1'b0;
    exp_req.push_back(16'h7788); exp_b.push_back(2'b10);
    fork
      send_aw(32'hFFFF_FF77);
      send_w(32'h1234_5688);
    join
    wait_cond(0, "req_wait_nack");
    ack_pulse(1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check("b_hold", 32'({BVALID, BRESP}), 32'({1'b1, 2'b10}));
    end
    @(posedge ACLK); #1;
    BREADY = 1'b1;
    @(posedge ACLK); #1;

    // Pending write blocks the request until it falls; WDATA[31:8] dropped.
    PENDING_WR = 1'b1;
    exp_req.push_back(16'h3344); exp_b.push_back(2'b00);
    send_aw(32'h0000_0033);
    send_w(32'hABCD_EF44);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check("pending_wr_block", 32'(VALID_ADDR_DATA_OUT), 32'd0);
    end
    @(posedge ACLK); #1;
    PENDING_WR = 1'b0;
    finish_write(1'b1);

    // Read, held off by a pending read first.
    PENDING_RD = 1'b1;
    exp_trig.push_back(16'h0200);
    send_ar(32'h0000_0002);
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      check("pending_rd_block", 32'(I2C_MASTER_TRIGGER), 32'd0);
    end
    @(posedge ACLK); #1;
    PENDING_RD = 1'b0;
    wait_cond(2, "trig_wait");
    exp_rack.push_back(1'b1); exp_r.push_back({8'h0A, 2'b00});
    @(posedge ACLK); #1;
    RDATA_VALID = 1'b1; RDATA_OUT = 8'h0A;
    @(posedge ACLK); #1;
    RDATA_VALID = 1'b0; RDATA_OUT = 8'h00;
    for (int i = 0; i < 2; i++) begin
      @(negedge ACLK);
      check("r_hold", 32'({RVALID, RDATA, RRESP}), 32'({1'b1, 8'h0A, 2'b00}));
    end
    @(posedge ACLK); #1;
    RREADY = 1'b1;
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    @(negedge ACLK);
    check("rvalid_clear", 32'(RVALID), 32'd0);
    check("ado_hold", 32'(ADDR_DATA_OUT), 32'h0200);

    // Reset during W_WAIT aborts with all outputs low; next write is normal.
    exp_req.push_back(16'h1122);
    send_aw(32'h0000_0011);
    send_w(32'h0000_0022);
    wait_cond(0, "req_wait_abort");
    @(posedge ACLK); #1;
    ARESETn = 1'b0;
    #1;
    check("abort_flags", 32'({AWREADY, WREADY, BVALID, ARREADY, RVALID,
                              VALID_ADDR_DATA_OUT, I2C_MASTER_TRIGGER, RDATA_VALID_ACK,
                              BRESP, RRESP, RDATA}), 32'd0);
    check("abort_ado", 32'(ADDR_DATA_OUT), 32'd0);
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    exp_req.push_back(16'h5566); exp_b.push_back(2'b00);
    send_aw(32'h0000_0055);
    send_w(32'h0000_0066);
    finish_write(1'b1);

    repeat (5) @(negedge ACLK);
    check("queues_empty", 32'(exp_req.size() + exp_trig.size() + exp_b.size() +
                              exp_r.size() + exp_rack.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
